// File: rtl/input_conditioner.sv
// Board input conditioner: two-flop synchronizer plus counter debouncer per switch/key bit.
// Define KEY_EDGE_LATCH_EN to add per-key sticky press flags on o_keys_data[7:4].
module input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned NUM_SW          = 18,
   parameter int unsigned NUM_KEY         = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SW-1:0]  i_sw_raw,
   input  logic [NUM_KEY-1:0] i_key_raw,
   input  logic [NUM_KEY-1:0] i_key_clr,
   output logic [31:0]        o_sw_data,
   output logic [31:0]        o_keys_data
);

   localparam int unsigned NumBits = NUM_SW + NUM_KEY;
   localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   // Keys are active-low on the board: their sync flops idle high and their level is inverted.
   localparam logic [NumBits-1:0] KeyMask = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

   logic [NumBits-1:0] raw;
   logic [NumBits-1:0] meta_q;
   logic [NumBits-1:0] sync_q;
   logic [NumBits-1:0] level;
   logic [NumBits-1:0] deb_q;
   logic [NumBits-1:0] deb_d;
   logic [CntW-1:0]    cnt_q [NumBits];
   logic [CntW-1:0]    cnt_d [NumBits];
   logic [NUM_KEY-1:0] key_flags;

   assign raw   = {i_key_raw, i_sw_raw};
   assign level = sync_q ^ KeyMask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= KeyMask;
         sync_q <= KeyMask;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
      end
   end

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NumBits; i++) begin
         cnt_d[i] = cnt_q[i];
         if (level[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            cnt_d[i] = '0;
            deb_d[i] = ~deb_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= '0;
         for (int i = 0; i < NumBits; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < NumBits; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef KEY_EDGE_LATCH_EN
   logic [NUM_KEY-1:0] flag_q;
   logic [NUM_KEY-1:0] flag_d;
   logic [NUM_KEY-1:0] key_rise;

   // A new press wins over a clear arriving on the same edge.
   assign key_rise = deb_d[NumBits-1 -: NUM_KEY] & ~deb_q[NumBits-1 -: NUM_KEY];
   assign flag_d   = (flag_q & ~i_key_clr) | key_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= '0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign key_flags = flag_q;
`else
   logic unused_key_clr;
   assign unused_key_clr = ^i_key_clr;
   assign key_flags      = '0;
`endif

   always_comb begin
      o_sw_data                  = '0;
      o_sw_data[NUM_SW-1:0]      = deb_q[NUM_SW-1:0];
      o_keys_data                = '0;
      o_keys_data[NUM_KEY-1:0]   = deb_q[NumBits-1 -: NUM_KEY];
      o_keys_data[4 +: NUM_KEY]  = key_flags;
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: vector table, corner-case sequences and
// randomized stimulus against a sliding-window debounce model.
module tb_input_conditioner;

   localparam int D = 4;
`ifdef KEY_EDGE_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] sw_raw;
   logic [3:0]  key_raw;
   logic [3:0]  key_clr;
   logic [31:0] o_sw_data;
   logic [31:0] o_keys_data;

   int checks = 0;
   int errors = 0;

   input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .NUM_SW         (18),
      .NUM_KEY        (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sw_raw   (sw_raw),
      .i_key_raw  (key_raw),
      .i_key_clr  (key_clr),
      .o_sw_data  (o_sw_data),
      .o_keys_data(o_keys_data)
   );

   always #5 clk = ~clk;

   // Model: level seen by the debouncer lags the pin by two edges; a bit flips once the
   // last D levels since its previous flip all disagree with its debounced value.
   logic [21:0] m_meta, m_sync, m_deb;
   logic [3:0]  m_flag;
   logic [21:0] hist[$];
   int          last_flip[22];

   task automatic model_reset();
      m_meta = {4'hF, 18'h0};
      m_sync = {4'hF, 18'h0};
      m_deb  = '0;
      m_flag = '0;
      hist.delete();
      for (int i = 0; i < 22; i++) last_flip[i] = -1;
   endtask

   task automatic model_step();
      logic [21:0] old_deb;
      logic [3:0]  rise;
      int          e;
      bit          all_diff;
      if (!rst_n) return;
      old_deb = m_deb;
      hist.push_back(m_sync ^ {4'hF, 18'h0});
      e = hist.size() - 1;
      for (int i = 0; i < 22; i++) begin
         if (e - last_flip[i] >= D) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) if (hist[e-k][i] == old_deb[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_deb[i]     = ~old_deb[i];
               last_flip[i] = e;
            end
         end
      end
      rise = m_deb[21:18] & ~old_deb[21:18];
      if (LATCH) m_flag = (m_flag & ~key_clr) | rise;
      m_sync = m_meta;
      m_meta = {key_raw, sw_raw};
   endtask

   function automatic logic [31:0] exp_sw_f();
      return {14'h0, m_deb[17:0]};
   endfunction

   function automatic logic [31:0] exp_keys_f();
      return {24'h0, (LATCH ? m_flag : 4'h0), m_deb[21:18]};
   endfunction

   function automatic logic [31:0] keys_word(input logic [3:0] lo, input logic [3:0] fl);
      return {24'h0, (LATCH ? fl : 4'h0), lo};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model_sw", o_sw_data, exp_sw_f());
      chk("model_keys", o_keys_data, exp_keys_f());
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      model_reset();
      repeat (cycles) begin
         tick();
         chk("rst_sw", o_sw_data, 32'h0);
         chk("rst_keys", o_keys_data, 32'h0);
      end
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [17:0] sw;
      logic [3:0]  key;
      logic [3:0]  clr;
      int          n;
      logic [31:0] exp_sw;
      logic [3:0]  exp_lo;
      logic [3:0]  exp_fl;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int hold;
      sw_raw  = 18'h0;
      key_raw = 4'hF;
      key_clr = 4'h0;
      rst_n   = 1'b0;
      model_reset();
      #1;

      // Reset with every input active, then settle latency after release.
      sw_raw  = 18'h3FFFF;
      key_raw = 4'h0;
      do_reset(3);
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e < 6) begin
            chk("rel_sw_early", o_sw_data, 32'h0);
            chk("rel_keys_early", o_keys_data, 32'h0);
         end else begin
            chk("rel_sw_final", o_sw_data, 32'h0003FFFF);
            chk("rel_keys_final", o_keys_data, keys_word(4'hF, 4'hF));
         end
      end

      sw_raw  = 18'h0;
      key_raw = 4'hF;
      do_reset(2);

      vecs[0] = '{18'h00000, 4'hF, 4'h0, 8, 32'h00000000, 4'h0, 4'h0};
      vecs[1] = '{18'h2A5A5, 4'hF, 4'h0, 5, 32'h00000000, 4'h0, 4'h0};
      vecs[2] = '{18'h2A5A5, 4'hF, 4'h0, 1, 32'h0002A5A5, 4'h0, 4'h0};
      vecs[3] = '{18'h2A5A5, 4'hE, 4'h0, 3, 32'h0002A5A5, 4'h0, 4'h0};
      vecs[4] = '{18'h2A5A5, 4'hF, 4'h0, 8, 32'h0002A5A5, 4'h0, 4'h0};
      vecs[5] = '{18'h2A5A5, 4'hE, 4'h0, 5, 32'h0002A5A5, 4'h0, 4'h0};
      vecs[6] = '{18'h2A5A5, 4'hE, 4'h0, 1, 32'h0002A5A5, 4'h1, 4'h1};
      vecs[7] = '{18'h2A5A5, 4'hF, 4'h0, 6, 32'h0002A5A5, 4'h0, 4'h1};
      vecs[8] = '{18'h2A5A5, 4'hF, 4'h1, 1, 32'h0002A5A5, 4'h0, 4'h0};
      vecs[9] = '{18'h00000, 4'hF, 4'h0, 6, 32'h00000000, 4'h0, 4'h0};
      for (int v = 0; v < 10; v++) begin
         sw_raw  = vecs[v].sw;
         key_raw = vecs[v].key;
         key_clr = vecs[v].clr;
         repeat (vecs[v].n) tick();
         chk($sformatf("vec%0d_sw", v), o_sw_data, vecs[v].exp_sw);
         chk($sformatf("vec%0d_keys", v), o_keys_data, keys_word(vecs[v].exp_lo, vecs[v].exp_fl));
      end
      key_clr = 4'h0;

      // Sticky flag on key 1, including a clear on the same edge as a new press.
      key_raw = 4'hD;
      repeat (6) tick();
      chk("sticky_pressed", o_keys_data, keys_word(4'h2, 4'h2));
      key_raw = 4'hF;
      repeat (6) tick();
      chk("sticky_released", o_keys_data, keys_word(4'h0, 4'h2));
      key_clr = 4'h2;
      tick();
      key_clr = 4'h0;
      chk("sticky_cleared", o_keys_data, 32'h0);
      key_raw = 4'hD;
      repeat (5) tick();
      chk("sticky_prepress", o_keys_data, 32'h0);
      key_clr = 4'h2;
      tick();
      key_clr = 4'h0;
      chk("sticky_set_wins", o_keys_data, keys_word(4'h2, 4'h2));
      key_raw = 4'hF;
      repeat (6) tick();
      key_clr = 4'hF;
      tick();
      key_clr = 4'h0;
      chk("sticky_cleanup", o_keys_data, 32'h0);

      // Key 2 bounces every 2 cycles, then is held pressed.
      for (int c = 0; c < 20; c++) begin
         key_raw[2] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         chk("bounce_hold", {31'h0, o_keys_data[2]}, 32'h0);
      end
      key_raw[2] = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("bounce_settle", {31'h0, o_keys_data[2]}, (e == 6) ? 32'h1 : 32'h0);
      end
      key_raw = 4'hF;
      repeat (8) tick();

      // Reset mid-count on key 3 restarts the count.
      key_raw = 4'h7;
      repeat (4) tick();
      do_reset(2);
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("rst_midcount", {31'h0, o_keys_data[3]}, (e == 6) ? 32'h1 : 32'h0);
      end
      key_raw = 4'hF;
      repeat (8) tick();

      // Randomized stimulus with variable hold times.
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset(2);
         if (hold == 0) begin
            sw_raw  = 18'($urandom);
            key_raw = 4'($urandom);
            hold    = $urandom_range(1, 9);
         end
         hold--;
         key_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
